// File: rtl/cory_yuv444to422_if.sv
// Valid/ready stream bundle with a line-last sideband.
// The master drives v/d/l, the slave drives r.
interface cory_yuv444to422_if #(
  parameter int DW = 24
);
  logic          v;
  logic [DW-1:0] d;
  logic          l;
  logic          r;

  modport master (output v, output d, output l, input r);
  modport slave  (input v, input d, input l, output r);
endinterface

// File: rtl/cory_yuv444to422.sv
// YUV 4:4:4 to 4:2:2 packer.
// Consumes {Y,U,V} pixels and emits {Y0,U,Y1,V} pairs. Chroma is either the
// rounded average of the pair or the first pixel's chroma. A line that ends
// on an even pixel is closed with a padded pair that repeats that pixel's luma.
module cory_yuv444to422 #(
  parameter bit AVG = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cory_yuv444to422_if.slave    a,
  cory_yuv444to422_if.master   z
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_PAD   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [7:0]  hy_q, hy_d;
  logic [7:0]  hu_q, hu_d;
  logic [7:0]  hv_q, hv_d;
  logic        zv_q, zv_d;
  logic [31:0] zd_q, zd_d;
  logic        zl_q, zl_d;

  logic        out_free_s;
  logic        a_r_s;
  logic        in_xfer_s;

  // Rounded 9-bit average, or pass-through of the first pixel's chroma.
  function automatic logic [7:0] chroma(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] sum;
    sum = {1'b0, x} + {1'b0, y} + 9'd1;
    if (AVG) begin
      chroma = sum[8:1];
    end else begin
      chroma = x;
    end
  endfunction

  // Input readiness depends only on state and output-slot availability.
  always_comb begin
    out_free_s = !zv_q || z.r;
    case (state_q)
      ST_EMPTY: a_r_s = 1'b1;
      ST_HALF:  a_r_s = out_free_s;
      ST_PAD:   a_r_s = 1'b0;
      default:  a_r_s = 1'b0;
    endcase
    in_xfer_s = a.v && a_r_s;
  end

  assign a.r = a_r_s;
  assign z.v = zv_q;
  assign z.d = zd_q;
  assign z.l = zl_q;

  // Next-state, hold-register and output-register computation.
  always_comb begin
    state_d = state_q;
    hy_d    = hy_q;
    hu_d    = hu_q;
    hv_d    = hv_q;
    zd_d    = zd_q;
    zl_d    = zl_q;
    // A sent pair empties the output slot unless a new pair overwrites it below.
    if (zv_q && z.r) begin
      zv_d = 1'b0;
    end else begin
      zv_d = zv_q;
    end
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer_s) begin
          hy_d    = a.d[23:16];
          hu_d    = a.d[15:8];
          hv_d    = a.d[7:0];
          state_d = a.l ? ST_PAD : ST_HALF;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_HALF: begin
        if (in_xfer_s) begin
          zd_d    = {hy_q, chroma(hu_q, a.d[15:8]), a.d[23:16], chroma(hv_q, a.d[7:0])};
          zl_d    = a.l;
          zv_d    = 1'b1;
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_HALF;
        end
      end
      ST_PAD: begin
        // Padded pair repeats the held luma and keeps its chroma unaveraged.
        if (out_free_s) begin
          zd_d    = {hy_q, hu_q, hy_q, hv_q};
          zl_d    = 1'b1;
          zv_d    = 1'b1;
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_PAD;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State, hold and output registers; reset drops any half-built pair.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      hy_q    <= 8'h00;
      hu_q    <= 8'h00;
      hv_q    <= 8'h00;
      zv_q    <= 1'b0;
      zd_q    <= 32'h0000_0000;
      zl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hy_q    <= hy_d;
      hu_q    <= hu_d;
      hv_q    <= hv_d;
      zv_q    <= zv_d;
      zd_q    <= zd_d;
      zl_q    <= zl_d;
    end
  end

endmodule

// File: tb/tb_cory_yuv444to422.sv
// Directed self-checking bench for cory_yuv444to422 (AVG=1 main instance,
// AVG=0 side instance for the decimation check).
module tb_cory_yuv444to422;

  logic clk;
  logic reset_n;

  cory_yuv444to422_if #(.DW(24)) a_if ();
  cory_yuv444to422_if #(.DW(32)) z_if ();
  cory_yuv444to422_if #(.DW(24)) a0_if ();
  cory_yuv444to422_if #(.DW(32)) z0_if ();

  cory_yuv444to422 #(.AVG(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a_if),
    .z       (z_if)
  );

  cory_yuv444to422 #(.AVG(1'b0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a0_if),
    .z       (z0_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic in_acc;
  int in_cnt;
  logic [31:0] got_q[$];
  logic        gotl_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vv, input logic [23:0] dd, input logic ll);
    a_if.v = vv;
    a_if.d = dd;
    a_if.l = ll;
  endtask

  // One clock: note transfers just before the edge, return #1 after it.
  task automatic cyc();
    @(negedge clk);
    in_acc = a_if.v && a_if.r;
    if (in_acc) in_cnt++;
    if (z_if.v && z_if.r) begin
      got_q.push_back(z_if.d);
      gotl_q.push_back(z_if.l);
    end
    @(posedge clk);
    #1;
  endtask

  logic [23:0] bp_pix [6];
  int          idx;
  int          vpos[$];
  logic        ar_low;
  logic        const_ok;
  logic        have_ref;
  logic [31:0] ref_d;
  logic [31:0] exp_d;

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 24'h000000, 1'b0);
    z_if.r = 1'b1;
    a0_if.v = 1'b0; a0_if.d = 24'h000000; a0_if.l = 1'b0;
    z0_if.r = 1'b1;
    in_cnt = 0;
    cyc();
    cyc();

    // Reset state
    chk("rst_a_r", {31'd0, a_if.r}, 32'd1);
    chk("rst_z_v", {31'd0, z_if.v}, 32'd0);
    chk("rst_z_d", z_if.d, 32'h0000_0000);
    chk("rst_z_l", {31'd0, z_if.l}, 32'd0);
    reset_n = 1'b1;
    cyc();

    // Two-pixel line, both chroma modes
    drive(1'b1, 24'h108080, 1'b0);
    a0_if.v = 1'b1; a0_if.d = 24'h108080; a0_if.l = 1'b0;
    cyc();
    chk("pair_not_yet", {31'd0, z_if.v}, 32'd0);
    drive(1'b1, 24'h20817F, 1'b1);
    a0_if.d = 24'h20817F; a0_if.l = 1'b1;
    cyc();
    drive(1'b0, 24'h000000, 1'b0);
    a0_if.v = 1'b0;
    chk("pair_v", {31'd0, z_if.v}, 32'd1);
    chk("pair_avg_d", z_if.d, 32'h1081_2080);
    chk("pair_l", {31'd0, z_if.l}, 32'd1);
    chk("pair_dec_d", z0_if.d, 32'h1080_2080);
    chk("pair_dec_v", {31'd0, z0_if.v}, 32'd1);
    cyc();
    chk("pair_drained", {31'd0, z_if.v}, 32'd0);

    // Odd line of three pixels: averaged pair then padded pair
    drive(1'b1, 24'h1040C0, 1'b0);
    cyc();
    drive(1'b1, 24'h2060A0, 1'b0);
    cyc();
    chk("odd_p1_d", z_if.d, 32'h1050_20B0);
    chk("odd_p1_l", {31'd0, z_if.l}, 32'd0);
    drive(1'b1, 24'h30F010, 1'b1);
    cyc();
    drive(1'b0, 24'h000000, 1'b0);
    chk("pad_a_r", {31'd0, a_if.r}, 32'd0);
    cyc();
    chk("pad_v", {31'd0, z_if.v}, 32'd1);
    chk("pad_d", z_if.d, 32'h30F0_3010);
    chk("pad_l", {31'd0, z_if.l}, 32'd1);
    cyc();

    // Continuous stream of eight pixels
    got_q.delete(); gotl_q.delete();
    ar_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, {i[7:0], 8'(4 * i), 8'(255 - i)}, (i == 7));
      else drive(1'b0, 24'h000000, 1'b0);
      cyc();
      if (i < 8 && !in_acc) ar_low = 1'b1;
      if (z_if.v) vpos.push_back(i);
    end
    chk("stream_ar_low", {31'd0, ar_low}, 32'd0);
    chk("stream_nvalid", vpos.size(), 32'd4);
    chk("stream_npairs", got_q.size(), 32'd4);
    if (vpos.size() == 4) begin
      for (int k = 1; k < 4; k++) chk("stream_gap", vpos[k] - vpos[k-1], 32'd2);
    end
    if (got_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        exp_d = {8'(2 * k), 8'(8 * k + 2), 8'(2 * k + 1), 8'(255 - 2 * k)};
        chk("stream_d", got_q[k], exp_d);
      end
      chk("stream_last_l", {31'd0, gotl_q[3]}, 32'd1);
      chk("stream_first_l", {31'd0, gotl_q[0]}, 32'd0);
    end

    // Backpressure: ten stalled cycles with six pixels offered
    got_q.delete(); gotl_q.delete();
    bp_pix[0] = 24'h112030; bp_pix[1] = 24'h122232;
    bp_pix[2] = 24'h134050; bp_pix[3] = 24'h144151;
    bp_pix[4] = 24'h156070; bp_pix[5] = 24'h166070;
    z_if.r = 1'b0;
    idx = 0;
    const_ok = 1'b1;
    have_ref = 1'b0;
    ref_d = 32'h0;
    for (int c = 0; c < 10; c++) begin
      if (idx < 6) drive(1'b1, bp_pix[idx], (idx == 5));
      else drive(1'b0, 24'h000000, 1'b0);
      cyc();
      if (in_acc) idx++;
      if (z_if.v) begin
        if (!have_ref) begin
          ref_d = z_if.d;
          have_ref = 1'b1;
        end else if (z_if.d !== ref_d) begin
          const_ok = 1'b0;
        end
      end
    end
    chk("bp_accepts", idx, 32'd3);
    chk("bp_const", {31'd0, const_ok}, 32'd1);
    chk("bp_held_d", z_if.d, 32'h1121_1231);
    chk("bp_a_r", {31'd0, a_if.r}, 32'd0);
    z_if.r = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (idx < 6) drive(1'b1, bp_pix[idx], (idx == 5));
      else drive(1'b0, 24'h000000, 1'b0);
      cyc();
      if (in_acc) idx++;
    end
    chk("bp_total_in", idx, 32'd6);
    chk("bp_npairs", got_q.size(), 32'd3);
    if (got_q.size() == 3) begin
      chk("bp_d0", got_q[0], 32'h1121_1231);
      chk("bp_d1", got_q[1], 32'h1341_1451);
      chk("bp_d2", got_q[2], 32'h1560_1670);
      chk("bp_l2", {31'd0, gotl_q[2]}, 32'd1);
    end

    // Rounding extremes
    drive(1'b1, 24'h01FF00, 1'b0); cyc();
    drive(1'b1, 24'h02FF01, 1'b0); cyc();
    chk("round_hi_d", z_if.d, 32'h01FF_0201);
    drive(1'b1, 24'h0300FE, 1'b0); cyc();
    drive(1'b1, 24'h0400FF, 1'b1); cyc();
    drive(1'b0, 24'h000000, 1'b0);
    chk("round_lo_d", z_if.d, 32'h0300_04FF);
    cyc();

    // Asynchronous reset while a pixel is held and a pair is pending
    z_if.r = 1'b0;
    drive(1'b1, 24'h303030, 1'b0); cyc();
    drive(1'b1, 24'h404040, 1'b0); cyc();
    drive(1'b1, 24'h55EEEE, 1'b0); cyc();
    drive(1'b0, 24'h000000, 1'b0);
    chk("prerst_v", {31'd0, z_if.v}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_v", {31'd0, z_if.v}, 32'd0);
    chk("arst_d", z_if.d, 32'h0000_0000);
    chk("arst_a_r", {31'd0, a_if.r}, 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    z_if.r = 1'b1;
    drive(1'b1, 24'hA01010, 1'b0); cyc();
    chk("post_rst_half", {31'd0, z_if.v}, 32'd0);
    drive(1'b1, 24'hB03030, 1'b1); cyc();
    drive(1'b0, 24'h000000, 1'b0);
    chk("post_rst_d", z_if.d, 32'hA020_B020);
    chk("post_rst_l", {31'd0, z_if.l}, 32'd1);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
